// File: rtl/mcmc_step_scheduler.sv
// Iteration sequencer for the MCMC sampler: chooser enable, latch chosen variable, dispatch to its proposal unit.
// Latency: 3 cycles minimum per iteration (CHOOSE, LATCH, one DISPATCH); every output is a flop.
// Backpressure: a unit request is held until that unit's done; a watchdog bounds the wait; abort wins over all.
module mcmc_step_scheduler #(
    parameter int IDX_W          = 8,
    parameter int ITER_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic              in_start,
    input  logic              in_abort,
    input  logic [ITER_W-1:0] in_iterations,
    output logic              out_chooser_enable,
    input  logic [1:0]        in_choosen_type,
    input  logic [IDX_W-1:0]  in_choosen_index,
    output logic [1:0]        out_var_type,
    output logic [IDX_W-1:0]  out_var_index,
    output logic              out_bool_req,
    output logic              out_int_req,
    output logic              out_disc_req,
    input  logic              in_bool_done,
    input  logic              in_int_done,
    input  logic              in_disc_done,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_error,
    output logic [ITER_W-1:0] out_iteration_count
);
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Last watchdog value seen in DISPATCH; the edge leaving it lands on TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] TYPE_BOOL = 2'd0;
    localparam logic [1:0] TYPE_INT  = 2'd1;
    localparam logic [1:0] TYPE_DISC = 2'd2;
    localparam logic [1:0] TYPE_INV  = 2'd3;

    typedef enum logic [1:0] {IDLE, CHOOSE, LATCH, DISPATCH} state_t;

    state_t            state, state_nxt;
    logic [ITER_W-1:0] target, target_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic [ITER_W-1:0] count_nxt;
    logic [ITER_W-1:0] count_inc;
    logic [1:0]        var_type_nxt;
    logic [IDX_W-1:0]  var_index_nxt;
    logic              bool_req_nxt, int_req_nxt, disc_req_nxt;
    logic              enable_nxt, done_nxt, error_nxt, busy_nxt;
    logic              unit_done;

    assign count_inc = out_iteration_count + 1'b1;
    assign unit_done = (out_bool_req & in_bool_done) |
                       (out_int_req  & in_int_done)  |
                       (out_disc_req & in_disc_done);

    always_comb begin
        state_nxt     = state;
        target_nxt    = target;
        wd_nxt        = wd;
        count_nxt     = out_iteration_count;
        var_type_nxt  = out_var_type;
        var_index_nxt = out_var_index;
        bool_req_nxt  = 1'b0;
        int_req_nxt   = 1'b0;
        disc_req_nxt  = 1'b0;
        enable_nxt    = 1'b0;
        done_nxt      = 1'b0;
        error_nxt     = out_error;

        if (in_abort && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        error_nxt  = 1'b0;
                        count_nxt  = '0;
                        target_nxt = in_iterations;
                        if (in_iterations == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            state_nxt  = CHOOSE;
                            enable_nxt = 1'b1;
                        end
                    end
                end
                CHOOSE: begin
                    state_nxt = LATCH;
                end
                LATCH: begin
                    var_type_nxt  = in_choosen_type;
                    var_index_nxt = in_choosen_index;
                    wd_nxt        = '0;
                    case (in_choosen_type)
                        TYPE_BOOL: bool_req_nxt = 1'b1;
                        TYPE_INT:  int_req_nxt  = 1'b1;
                        TYPE_DISC: disc_req_nxt = 1'b1;
                        default:   ;
                    endcase
                    if (in_choosen_type == TYPE_INV) begin
                        error_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DISPATCH;
                    end
                end
                DISPATCH: begin
                    // A done arriving on the timeout cycle still completes the iteration.
                    if (unit_done) begin
                        count_nxt = count_inc;
                        if (count_inc == target) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt  = CHOOSE;
                            enable_nxt = 1'b1;
                        end
                    end else if (wd == WD_LAST) begin
                        error_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        wd_nxt       = wd + 1'b1;
                        bool_req_nxt = out_bool_req;
                        int_req_nxt  = out_int_req;
                        disc_req_nxt = out_disc_req;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state               <= IDLE;
            target              <= '0;
            wd                  <= '0;
            out_iteration_count <= '0;
            out_var_type        <= '0;
            out_var_index       <= '0;
            out_bool_req        <= 1'b0;
            out_int_req         <= 1'b0;
            out_disc_req        <= 1'b0;
            out_chooser_enable  <= 1'b0;
            out_done            <= 1'b0;
            out_error           <= 1'b0;
            out_busy            <= 1'b0;
        end else begin
            state               <= state_nxt;
            target              <= target_nxt;
            wd                  <= wd_nxt;
            out_iteration_count <= count_nxt;
            out_var_type        <= var_type_nxt;
            out_var_index       <= var_index_nxt;
            out_bool_req        <= bool_req_nxt;
            out_int_req         <= int_req_nxt;
            out_disc_req        <= disc_req_nxt;
            out_chooser_enable  <= enable_nxt;
            out_done            <= done_nxt;
            out_error           <= error_nxt;
            out_busy            <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_mcmc_step_scheduler.sv
// Randomized bench for mcmc_step_scheduler: per-run outcome predicted from an iteration-level timeline model.
// Chooser and proposal units are modelled behaviourally; stray dones from idle units are injected.
module tb_mcmc_step_scheduler;
    localparam int IDX_W  = 8;
    localparam int ITER_W = 16;
    localparam int TMO    = 8;
    localparam int MAXN   = 8;

    logic              in_clock = 1'b0;
    logic              in_reset;
    logic              in_start, in_abort;
    logic [ITER_W-1:0] in_iterations;
    logic              out_chooser_enable;
    logic [1:0]        in_choosen_type;
    logic [IDX_W-1:0]  in_choosen_index;
    logic [1:0]        out_var_type;
    logic [IDX_W-1:0]  out_var_index;
    logic              out_bool_req, out_int_req, out_disc_req;
    logic              in_bool_done, in_int_done, in_disc_done;
    logic              out_busy, out_done, out_error;
    logic [ITER_W-1:0] out_iteration_count;

    mcmc_step_scheduler #(.IDX_W(IDX_W), .ITER_W(ITER_W), .TIMEOUT_CYCLES(TMO)) dut (
        .in_clock(in_clock), .in_reset(in_reset), .in_start(in_start), .in_abort(in_abort),
        .in_iterations(in_iterations), .out_chooser_enable(out_chooser_enable),
        .in_choosen_type(in_choosen_type), .in_choosen_index(in_choosen_index),
        .out_var_type(out_var_type), .out_var_index(out_var_index),
        .out_bool_req(out_bool_req), .out_int_req(out_int_req), .out_disc_req(out_disc_req),
        .in_bool_done(in_bool_done), .in_int_done(in_int_done), .in_disc_done(in_disc_done),
        .out_busy(out_busy), .out_done(out_done), .out_error(out_error),
        .out_iteration_count(out_iteration_count)
    );

    always #5 in_clock = ~in_clock;

    int types[MAXN];
    int lat[MAXN];
    int idx[MAXN];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Walk the run as a timeline of busy cycles (1 = first CHOOSE); abort at cycle k cuts it there.
    function automatic void model(input int n, input int k, output int busy, output int en,
                                  output int done, output int err, output int cnt, output int disp);
        int cyc, len, fin;
        busy = 0; en = 0; done = 0; err = 0; cnt = 0; disp = 0; cyc = 0;
        if (n == 0) begin
            done = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            en++;
            if (k != 0 && k <= cyc + 2) begin busy = k; return; end
            if (types[i] == 3) begin busy = cyc + 2; err = 1; return; end
            disp++;
            len = (lat[i] > TMO - 1) ? TMO - 1 : lat[i];
            fin = cyc + 2 + len;
            if (k != 0 && k <= fin) begin busy = k; return; end
            if (lat[i] > TMO - 1) begin busy = fin; err = 1; return; end
            cnt++;
            cyc = fin;
        end
        busy = cyc;
        done = 1;
    endfunction

    function automatic logic spur_bit(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic run(input int n, input int abort_at, input int spur, input int rst_at);
        int e_busy, e_en, e_done, e_err, e_cnt, e_disp;
        int busy_cyc, en_cyc, done_cnt, disp_cnt, viol, disp_n, it, cur, kind, aligned;
        logic prev_busy;
        bit finished, rst_hit;
        model(n, abort_at, e_busy, e_en, e_done, e_err, e_cnt, e_disp);
        busy_cyc = 0; en_cyc = 0; done_cnt = 0; disp_cnt = 0; viol = 0; disp_n = 0;
        it = 0; cur = 0; aligned = 0; prev_busy = 1'b0; finished = 0; rst_hit = 0;
        in_start = 1'b1;
        in_iterations = ITER_W'(n);
        @(negedge in_clock);
        in_start = 1'b0;
        chk("start_clears_error", 32'(out_error), 0);
        chk("start_clears_count", 32'(out_iteration_count), 0);
        for (int c = 0; c < 400 && !finished; c++) begin
            if (c > 0) @(negedge in_clock);
            if (out_busy) busy_cyc++;
            if (out_done) begin
                done_cnt++;
                if (!out_busy && (prev_busy || n == 0)) aligned = 1;
            end
            if (out_chooser_enable) begin
                cur = (it < MAXN) ? it : MAXN - 1;
                in_choosen_type  = 2'(types[cur]);
                in_choosen_index = IDX_W'(idx[cur]);
                it++;
                en_cyc++;
            end
            if ($countones({out_bool_req, out_int_req, out_disc_req}) > 1) viol++;
            kind = out_bool_req ? 0 : out_int_req ? 1 : out_disc_req ? 2 : -1;
            if (kind >= 0) begin
                disp_n++;
                if (disp_n == 1) begin
                    disp_cnt++;
                    chk("req_kind", kind, types[cur]);
                    chk("var_type", 32'(out_var_type), types[cur]);
                    chk("var_index", 32'(out_var_index), idx[cur]);
                end
                in_bool_done = spur_bit(spur);
                in_int_done  = spur_bit(spur);
                in_disc_done = spur_bit(spur);
                if (kind == 0) in_bool_done = (disp_n == lat[cur]);
                if (kind == 1) in_int_done  = (disp_n == lat[cur]);
                if (kind == 2) in_disc_done = (disp_n == lat[cur]);
            end else begin
                disp_n = 0;
                in_bool_done = 1'b0; in_int_done = 1'b0; in_disc_done = 1'b0;
            end
            in_abort = out_busy && (busy_cyc == abort_at);
            in_start = out_busy && ($urandom_range(0, 3) == 0);
            in_iterations = ITER_W'($urandom_range(1, 4));
            if (rst_at != 0 && out_busy && busy_cyc == rst_at) begin
                chk("pre_reset_int_req", 32'(out_int_req), 1);
                chk("pre_reset_count", 32'(out_iteration_count), 1);
                in_start = 1'b0; in_abort = 1'b0;
                in_bool_done = 1'b0; in_int_done = 1'b0; in_disc_done = 1'b0;
                in_reset = 1'b0;
                #1;
                chk("reset_reqs", 32'({out_bool_req, out_int_req, out_disc_req}), 0);
                chk("reset_busy", 32'(out_busy), 0);
                chk("reset_error", 32'(out_error), 0);
                chk("reset_count", 32'(out_iteration_count), 0);
                @(negedge in_clock);
                in_reset = 1'b1;
                @(negedge in_clock);
                chk("post_reset_idle", 32'({out_busy, out_chooser_enable}), 0);
                rst_hit = 1;
                finished = 1;
            end
            if (!out_busy && (prev_busy || n == 0)) finished = 1;
            prev_busy = out_busy;
        end
        in_start = 1'b0; in_abort = 1'b0;
        in_bool_done = 1'b0; in_int_done = 1'b0; in_disc_done = 1'b0;
        if (!finished) chk("run_cycle_bound", 0, 1);
        if (!rst_hit) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge in_clock);
                if (out_done) done_cnt++;
            end
            chk("busy_cycles", busy_cyc, e_busy);
            chk("enable_pulses", en_cyc, e_en);
            chk("done_pulses", done_cnt, e_done);
            chk("done_with_busy_fall", aligned, e_done);
            chk("error", 32'(out_error), e_err);
            chk("iteration_count", 32'(out_iteration_count), e_cnt);
            chk("dispatches", disp_cnt, e_disp);
            chk("req_onehot", viol, 0);
        end
    endtask

    task automatic set_iter(input int i, input int t, input int l);
        types[i] = t;
        lat[i]   = l;
        idx[i]   = int'($urandom_range(0, 255));
    endtask

    initial begin
        #1000000;
        $display("FAIL global_watchdog: simulation time bound exceeded");
        $fatal(1);
    end

    initial begin
        int n, k, sp;
        in_start = 1'b0; in_abort = 1'b0; in_iterations = '0;
        in_choosen_type = '0; in_choosen_index = '0;
        in_bool_done = 1'b0; in_int_done = 1'b0; in_disc_done = 1'b0;
        in_reset = 1'b1;
        #1 in_reset = 1'b0;
        #10;
        chk("rst_busy", 32'(out_busy), 0);
        chk("rst_outputs", 32'({out_chooser_enable, out_done, out_error,
                                 out_bool_req, out_int_req, out_disc_req}), 0);
        chk("rst_count", 32'(out_iteration_count), 0);
        chk("rst_var", 32'({out_var_type, out_var_index}), 0);
        @(negedge in_clock);
        in_reset = 1'b1;
        @(negedge in_clock);

        // three iterations, one of each type, fastest units
        set_iter(0, 0, 1); set_iter(1, 1, 1); set_iter(2, 2, 1);
        run(3, 0, 0, 0);
        // zero iterations
        run(0, 0, 0, 0);
        // integer unit never answers -> watchdog, then a clean run clears the error
        set_iter(0, 1, 20);
        run(1, 0, 0, 0);
        set_iter(0, 2, 2); set_iter(1, 0, 3);
        run(2, 0, 0, 0);
        // done on the watchdog's final cycle completes the iteration
        set_iter(0, 0, TMO - 1);
        run(1, 0, 0, 0);
        // invalid type from chooser
        set_iter(0, 3, 1);
        run(2, 0, 0, 0);
        // bool/disc dones held high while int request is pending
        set_iter(0, 1, 4); set_iter(1, 1, 2);
        run(2, 0, 2, 0);
        // abort on the same edge as third iteration's done
        for (int i = 0; i < 5; i++) set_iter(i, i % 3, 1);
        run(5, 9, 1, 0);
        // async reset in the middle of the second dispatch
        set_iter(0, 1, 1); set_iter(1, 1, 6); set_iter(2, 1, 6);
        run(3, 0, 0, 7);

        for (int r = 0; r < 40; r++) begin
            n  = int'($urandom_range(0, 6));
            k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : 0;
            sp = int'($urandom_range(0, 2));
            for (int i = 0; i < MAXN; i++)
                set_iter(i, ($urandom_range(0, 9) == 9) ? 3 : int'($urandom_range(0, 2)),
                         ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                                     : int'($urandom_range(1, 4)));
            run(n, k, sp, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
